// File: rtl/dbus_arb_pkg.sv
// Shared types and defaults for the two-master data bus arbiter.
package dbus_arb_pkg;

    typedef enum logic {ARB = 1'b0, LOCK = 1'b1} arb_state_t;

    typedef enum logic {SRC_IO = 1'b0, SRC_MEM = 1'b1} rd_src_t;

    localparam logic [15:0] MEMADDRBASE_DEFAULT = 16'h2000;

    // Addresses at or above the base belong to memory, everything below is io
    function automatic logic is_mem_addr(input logic [15:0] addr, input logic [15:0] base);
        return addr >= base;
    endfunction

endpackage

// File: rtl/dbus_decode.sv
// Address decode for the shared bus: splits write strobes between memory
// and io, and remembers which side a granted read went to so the returned
// data can be steered one cycle later.
module dbus_decode
    import dbus_arb_pkg::*;
#(
    parameter logic [15:0] MEMADDRBASE = MEMADDRBASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gnt,
    input  logic [1:0]  we,
    input  logic [15:0] addr,
    output logic [1:0]  mem_dwrite_en,
    output logic [1:0]  io_dwrite_en,
    output rd_src_t     rd_src
);

    logic sel_mem;

    // Strobes only reach a target when an access is actually granted this cycle
    always_comb begin
        sel_mem       = is_mem_addr(addr, MEMADDRBASE);
        mem_dwrite_en = (gnt && sel_mem)  ? we : 2'b00;
        io_dwrite_en  = (gnt && !sel_mem) ? we : 2'b00;
    end

    // Capture the read source on every granted read; it selects rdata next cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_src <= SRC_IO;
        end else if (gnt && (we == 2'b00)) begin
            rd_src <= sel_mem ? SRC_MEM : SRC_IO;
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master data bus arbiter: m0 (CPU) has priority, m1 (DMA) may lock the
// bus for bounded bursts. Optional feature macro: DBUS_ARB_STARVE_EN gives
// m1 one forced grant after MAXWAIT denied cycles.
module dbus_arbiter
    import dbus_arb_pkg::*;
#(
    parameter logic [15:0] MEMADDRBASE = MEMADDRBASE_DEFAULT,
    parameter int          MAXWAIT     = 8,
    parameter int          LOCKMAX     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [1:0]  m0_we,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic [1:0]  m1_we,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [15:0] m1_rdata,
    output logic [15:0] dread_addr,
    output logic [15:0] dwrite_addr,
    output logic [15:0] dwrite_data,
    output logic [1:0]  mem_dwrite_en,
    output logic [1:0]  io_dwrite_en,
    input  logic [15:0] mem_dread_data,
    input  logic [15:0] io_dread_data
);

    localparam int             LCW       = $clog2(LOCKMAX + 1);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCKMAX - 1);
    localparam logic [LCW-1:0] LOCK_FULL = LCW'(LOCKMAX);

    arb_state_t     state;
    logic [LCW-1:0] lock_cnt;
    logic           lock_expired;
    logic           starve;
    logic           cap_hit;
    logic           any_gnt;
    logic [1:0]     sel_we;
    logic [15:0]    sel_addr;
    logic [15:0]    sel_wdata;
    logic [15:0]    last_addr;
    logic [15:0]    rd_data;
    rd_src_t        rd_src;

`ifdef DBUS_ARB_STARVE_EN
    localparam int             WCW      = $clog2(MAXWAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAXWAIT);

    logic [WCW-1:0] wait_cnt;

    // Count consecutive denied m1 cycles, saturating at the starvation limit
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!m1_req || m1_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WCW'(1);
        end
    end

    assign starve = (wait_cnt == WAIT_MAX);
`else
    assign starve = 1'b0;
`endif

    // Grant decision; nothing is granted while reset is held low
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (reset) begin
            if (state == LOCK) begin
                m1_gnt = m1_req;
            end else if (lock_expired) begin
                m0_gnt = m0_req;
                m1_gnt = !m0_req && m1_req;
            end else if (starve && m1_req) begin
                m1_gnt = 1'b1;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = !m0_req && m1_req;
            end
        end
    end

    // The granted master drives the shared bus; addresses hold when idle
    always_comb begin
        any_gnt     = m0_gnt || m1_gnt;
        sel_we      = m1_gnt ? m1_we    : m0_we;
        sel_addr    = m1_gnt ? m1_addr  : m0_addr;
        sel_wdata   = m1_gnt ? m1_wdata : m0_wdata;
        dread_addr  = any_gnt ? sel_addr : last_addr;
        dwrite_addr = any_gnt ? sel_addr : last_addr;
        dwrite_data = any_gnt ? sel_wdata : 16'h0000;
        cap_hit     = m1_gnt && (lock_cnt == LOCK_LAST);
    end

    // Arbitration FSM: ARB picks a master, LOCK keeps m1 for a bounded burst
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ARB;
            lock_cnt     <= '0;
            lock_expired <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    lock_expired <= 1'b0;
                    if (m1_gnt && m1_lock && !lock_expired) begin
                        lock_cnt <= LCW'(1);
                        if (LOCKMAX > 1) begin
                            state <= LOCK;
                        end else begin
                            lock_expired <= 1'b1;
                        end
                    end
                end
                LOCK: begin
                    if (m1_gnt && (lock_cnt != LOCK_FULL)) begin
                        lock_cnt <= lock_cnt + LCW'(1);
                    end
                    if (cap_hit) begin
                        state        <= ARB;
                        lock_expired <= 1'b1;
                    end else if (!m1_req || !m1_lock) begin
                        state <= ARB;
                    end
                end
            endcase
        end
    end

    // Track which master owns the read in flight and the last bus address
    always_ff @(posedge clk) begin
        if (!reset) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            last_addr <= 16'h0000;
        end else begin
            m0_rvalid <= m0_gnt && (m0_we == 2'b00);
            m1_rvalid <= m1_gnt && (m1_we == 2'b00);
            if (any_gnt) begin
                last_addr <= sel_addr;
            end
        end
    end

    // Steer returned read data to the owner; zero when no read is returning
    always_comb begin
        rd_data  = (rd_src == SRC_MEM) ? mem_dread_data : io_dread_data;
        m0_rdata = m0_rvalid ? rd_data : 16'h0000;
        m1_rdata = m1_rvalid ? rd_data : 16'h0000;
    end

    dbus_decode #(
        .MEMADDRBASE(MEMADDRBASE)
    ) u_decode (
        .clk          (clk),
        .reset        (reset),
        .gnt          (any_gnt),
        .we           (sel_we),
        .addr         (sel_addr),
        .mem_dwrite_en(mem_dwrite_en),
        .io_dwrite_en (io_dwrite_en),
        .rd_src       (rd_src)
    );

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: a constant vector table, directed
// multi-cycle sequences and randomized traffic checked against a rule-level
// model. Honours DBUS_ARB_STARVE_EN when the design is built with it.
module tb_dbus_arbiter;

    localparam int          MAXWAIT = 8;
    localparam int          LOCKMAX = 16;
    localparam logic [15:0] BASE    = 16'h2000;
`ifdef DBUS_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        m0_req, m1_req, m1_lock;
    logic [1:0]  m0_we, m1_we;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata;
    logic [15:0] dread_addr, dwrite_addr, dwrite_data;
    logic [1:0]  mem_dwrite_en, io_dwrite_en;
    logic [15:0] mem_dread_data, io_dread_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst_n;
        logic        m0r;
        logic [1:0]  m0w;
        logic [15:0] m0a;
        logic [15:0] m0d;
        logic        m1r;
        logic [1:0]  m1w;
        logic [15:0] m1a;
        logic [15:0] m1d;
        logic        lk;
        logic [15:0] memd;
        logic [15:0] iod;
        logic        e_g0;
        logic        e_g1;
        logic [1:0]  e_mem;
        logic [1:0]  e_io;
        logic        e_rv0;
        logic        e_rv1;
        logic [15:0] e_rd0;
        logic [15:0] e_rd1;
    } vec_t;

    // Reference model state: what the bus should look like after the next edge
    bit          md_burst;
    int          md_burst_cnt;
    bit          md_m0_first;
    int          md_wait;
    int          md_rd_owner;
    bit          md_rd_mem;
    logic [15:0] md_last_addr;

    dbus_arbiter #(.MEMADDRBASE(BASE), .MAXWAIT(MAXWAIT), .LOCKMAX(LOCKMAX)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .dread_addr(dread_addr), .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data),
        .mem_dwrite_en(mem_dwrite_en), .io_dwrite_en(io_dwrite_en),
        .mem_dread_data(mem_dread_data), .io_dread_data(io_dread_data)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkv(
        input logic rst_n, input logic m0r, input logic [1:0] m0w, input logic [15:0] m0a,
        input logic [15:0] m0d, input logic m1r, input logic [1:0] m1w, input logic [15:0] m1a,
        input logic [15:0] m1d, input logic lk, input logic [15:0] memd, input logic [15:0] iod,
        input logic e_g0, input logic e_g1, input logic [1:0] e_mem, input logic [1:0] e_io,
        input logic e_rv0, input logic e_rv1, input logic [15:0] e_rd0, input logic [15:0] e_rd1);
        vec_t v;
        v.rst_n = rst_n; v.m0r = m0r; v.m0w = m0w; v.m0a = m0a; v.m0d = m0d;
        v.m1r = m1r; v.m1w = m1w; v.m1a = m1a; v.m1d = m1d; v.lk = lk;
        v.memd = memd; v.iod = iod;
        v.e_g0 = e_g0; v.e_g1 = e_g1; v.e_mem = e_mem; v.e_io = e_io;
        v.e_rv0 = e_rv0; v.e_rv1 = e_rv1; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset          = v.rst_n;
        m0_req         = v.m0r;
        m0_we          = v.m0w;
        m0_addr        = v.m0a;
        m0_wdata       = v.m0d;
        m1_req         = v.m1r;
        m1_we          = v.m1w;
        m1_addr        = v.m1a;
        m1_wdata       = v.m1d;
        m1_lock        = v.lk;
        mem_dread_data = v.memd;
        io_dread_data  = v.iod;
    endtask

    // Compare the DUT against the rule model for this cycle, then advance the model
    task automatic checkOutput();
        logic        e0, e1, granted;
        logic [1:0]  g_we;
        logic [15:0] g_addr, g_wd, rd;
        bit          cap;
        e0 = 1'b0;
        e1 = 1'b0;
        if (reset) begin
            if (md_burst) e1 = m1_req;
            else if (md_m0_first) begin
                if (m0_req) e0 = 1'b1; else e1 = m1_req;
            end else if (STARVE && md_wait >= MAXWAIT && m1_req) e1 = 1'b1;
            else if (m0_req) e0 = 1'b1;
            else e1 = m1_req;
        end
        granted = e0 | e1;
        g_we   = e1 ? m1_we : m0_we;
        g_addr = e1 ? m1_addr : m0_addr;
        g_wd   = e1 ? m1_wdata : m0_wdata;
        rd     = md_rd_mem ? mem_dread_data : io_dread_data;

        cmp("m0_gnt", {15'd0, m0_gnt}, {15'd0, e0});
        cmp("m1_gnt", {15'd0, m1_gnt}, {15'd0, e1});
        cmp("mem_dwrite_en", {14'd0, mem_dwrite_en}, (granted && g_addr >= BASE) ? {14'd0, g_we} : 16'd0);
        cmp("io_dwrite_en", {14'd0, io_dwrite_en}, (granted && g_addr < BASE) ? {14'd0, g_we} : 16'd0);
        cmp("dread_addr", dread_addr, granted ? g_addr : md_last_addr);
        cmp("dwrite_addr", dwrite_addr, granted ? g_addr : md_last_addr);
        if (granted) cmp("dwrite_data", dwrite_data, g_wd);
        cmp("m0_rvalid", {15'd0, m0_rvalid}, (md_rd_owner == 0) ? 16'd1 : 16'd0);
        cmp("m1_rvalid", {15'd0, m1_rvalid}, (md_rd_owner == 1) ? 16'd1 : 16'd0);
        cmp("m0_rdata", m0_rdata, (md_rd_owner == 0) ? rd : 16'd0);
        cmp("m1_rdata", m1_rdata, (md_rd_owner == 1) ? rd : 16'd0);

        if (!reset) begin
            md_burst = 0; md_burst_cnt = 0; md_m0_first = 0; md_wait = 0;
            md_rd_owner = -1; md_last_addr = 16'h0000;
        end else begin
            md_wait = (!m1_req || e1) ? 0 : ((md_wait + 1 > MAXWAIT) ? MAXWAIT : md_wait + 1);
            cap = 0;
            if (md_burst) begin
                if (e1) md_burst_cnt++;
                cap = (md_burst_cnt >= LOCKMAX);
                if (!m1_req || !m1_lock || cap) md_burst = 0;
            end else if (e1 && m1_lock && !md_m0_first) begin
                md_burst = 1;
                md_burst_cnt = 1;
            end
            md_m0_first = cap;
            md_rd_owner = (e0 && m0_we == 2'b00) ? 0 : ((e1 && m1_we == 2'b00) ? 1 : -1);
            if (granted && g_we == 2'b00) md_rd_mem = (g_addr >= BASE);
            if (granted) md_last_addr = g_addr;
        end
    endtask

    task automatic runCycle(input vec_t v);
        @(negedge clk);
        applyStimulus(v);
        #1;
        checkOutput();
    endtask

    // Shorthand for sequence cycles: random write data and read data
    task automatic seqCycle(input logic rst_n, input logic m0r, input logic [1:0] m0w,
                            input logic [15:0] m0a, input logic m1r, input logic [1:0] m1w,
                            input logic [15:0] m1a, input logic lk);
        runCycle(mkv(rst_n, m0r, m0w, m0a, 16'($urandom), m1r, m1w, m1a, 16'($urandom), lk,
                     16'($urandom), 16'($urandom), 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        vec_t tbl[12];
        int   m1_cnt, first_m1, burst_m1, late_m1;
        logic g0_hist[20];
        logic g1_hist[20];

        // rst m0r m0we m0addr m0wd  m1r m1we m1addr m1wd  lk memd iod | g0 g1 mem io rv0 rv1 rd0 rd1
        tbl[0]  = mkv(0, 0, 2'b00, 16'h0000, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 16'h1111, 16'h2222, 0, 0, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000);
        tbl[1]  = mkv(1, 1, 2'b00, 16'h2004, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 16'h1111, 16'h2222, 1, 0, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000);
        tbl[2]  = mkv(1, 0, 2'b00, 16'h0000, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 16'h3333, 16'h4444, 0, 0, 2'b00, 2'b00, 1, 0, 16'h3333, 16'h0000);
        tbl[3]  = mkv(1, 0, 2'b00, 16'h0000, 16'h0000, 1, 2'b11, 16'h0010, 16'hBEEF, 0, 16'h5555, 16'h6666, 0, 1, 2'b00, 2'b11, 0, 0, 16'h0000, 16'h0000);
        tbl[4]  = mkv(1, 1, 2'b00, 16'h1FFF, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 16'h0005, 16'h0006, 1, 0, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000);
        tbl[5]  = mkv(1, 1, 2'b00, 16'h2000, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 16'h0007, 16'h0008, 1, 0, 2'b00, 2'b00, 1, 0, 16'h0008, 16'h0000);
        tbl[6]  = mkv(1, 0, 2'b00, 16'h0000, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 16'h0009, 16'h000A, 0, 0, 2'b00, 2'b00, 1, 0, 16'h0009, 16'h0000);
        tbl[7]  = mkv(1, 1, 2'b01, 16'h3000, 16'h1234, 1, 2'b00, 16'h0100, 16'h0000, 0, 16'hAAAA, 16'hBBBB, 1, 0, 2'b01, 2'b00, 0, 0, 16'h0000, 16'h0000);
        tbl[8]  = mkv(1, 0, 2'b00, 16'h0000, 16'h0000, 1, 2'b10, 16'h2000, 16'h5678, 0, 16'hCCCC, 16'hDDDD, 0, 1, 2'b10, 2'b00, 0, 0, 16'h0000, 16'h0000);
        tbl[9]  = mkv(1, 0, 2'b00, 16'h0000, 16'h0000, 1, 2'b00, 16'h0004, 16'h0000, 0, 16'hEEEE, 16'hFFFF, 0, 1, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000);
        tbl[10] = mkv(1, 0, 2'b00, 16'h0000, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 16'h1234, 16'hABCD, 0, 0, 2'b00, 2'b00, 0, 1, 16'h0000, 16'hABCD);
        tbl[11] = mkv(1, 1, 2'b10, 16'h1FFF, 16'h9999, 0, 2'b00, 16'h0000, 16'h0000, 0, 16'h0101, 16'h0202, 1, 0, 2'b00, 2'b10, 0, 0, 16'h0000, 16'h0000);

        applyStimulus(tbl[0]);
        repeat (2) @(posedge clk);
        md_burst = 0; md_burst_cnt = 0; md_m0_first = 0; md_wait = 0;
        md_rd_owner = -1; md_rd_mem = 0; md_last_addr = 16'h0000;

        $display("[TB] vector table");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(tbl[i]);
            #1;
            cmp($sformatf("row%0d m0_gnt", i), {15'd0, m0_gnt}, {15'd0, tbl[i].e_g0});
            cmp($sformatf("row%0d m1_gnt", i), {15'd0, m1_gnt}, {15'd0, tbl[i].e_g1});
            cmp($sformatf("row%0d mem_en", i), {14'd0, mem_dwrite_en}, {14'd0, tbl[i].e_mem});
            cmp($sformatf("row%0d io_en", i), {14'd0, io_dwrite_en}, {14'd0, tbl[i].e_io});
            cmp($sformatf("row%0d m0_rvalid", i), {15'd0, m0_rvalid}, {15'd0, tbl[i].e_rv0});
            cmp($sformatf("row%0d m1_rvalid", i), {15'd0, m1_rvalid}, {15'd0, tbl[i].e_rv1});
            cmp($sformatf("row%0d m0_rdata", i), m0_rdata, tbl[i].e_rd0);
            cmp($sformatf("row%0d m1_rdata", i), m1_rdata, tbl[i].e_rd1);
            if (i == 3) cmp("row3 dwrite_data", dwrite_data, 16'hBEEF);
            checkOutput();
        end

        $display("[TB] both masters contend");
        seqCycle(1, 0, 2'b00, 16'h0000, 0, 2'b00, 16'h0000, 0);
        m1_cnt = 0;
        first_m1 = -1;
        for (int c = 1; c <= 20; c++) begin
            seqCycle(1, 1, 2'b00, 16'h2000, 1, 2'b00, 16'h0000, 0);
            if (m1_gnt === 1'b1) begin
                m1_cnt++;
                if (first_m1 < 0) first_m1 = c;
            end
        end
        cmp("contend m1 grants", 16'(m1_cnt), STARVE ? 16'd2 : 16'd0);
        cmp("contend first m1 cycle", 16'(first_m1), STARVE ? 16'd9 : 16'hFFFF);

        $display("[TB] locked burst past the cap");
        seqCycle(1, 0, 2'b00, 16'h0000, 0, 2'b00, 16'h0000, 0);
        for (int c = 0; c < 20; c++) begin
            seqCycle(1, (c != 0), 2'b00, 16'h2100, 1, 2'b00, 16'h2200, 1);
            g0_hist[c] = m0_gnt;
            g1_hist[c] = m1_gnt;
        end
        burst_m1 = 0;
        late_m1  = 0;
        for (int c = 0; c < 16; c++) if (g1_hist[c] === 1'b1) burst_m1++;
        for (int c = 16; c < 20; c++) if (g1_hist[c] === 1'b1) late_m1++;
        cmp("burst m1 grants", 16'(burst_m1), 16'd16);
        cmp("post-cap m0_gnt", {15'd0, g0_hist[16]}, 16'd1);
        cmp("post-cap m1_gnt", {15'd0, g1_hist[16]}, 16'd0);
        cmp("after-cap m1 grants", 16'(late_m1), 16'd0);

        $display("[TB] reset during a locked burst");
        seqCycle(1, 0, 2'b00, 16'h0000, 0, 2'b00, 16'h0000, 0);
        seqCycle(1, 0, 2'b00, 16'h0000, 1, 2'b00, 16'h2300, 1);
        repeat (3) seqCycle(1, 1, 2'b00, 16'h0040, 1, 2'b00, 16'h2300, 1);
        seqCycle(0, 1, 2'b11, 16'h2400, 1, 2'b11, 16'h2500, 1);
        cmp("reset m1_gnt", {15'd0, m1_gnt}, 16'd0);
        cmp("reset mem_en", {14'd0, mem_dwrite_en}, 16'd0);
        seqCycle(1, 1, 2'b00, 16'h0050, 1, 2'b00, 16'h2300, 1);
        cmp("release m0_gnt", {15'd0, m0_gnt}, 16'd1);
        cmp("release m1_gnt", {15'd0, m1_gnt}, 16'd0);
        cmp("release m0_rvalid", {15'd0, m0_rvalid}, 16'd0);
        cmp("release m1_rvalid", {15'd0, m1_rvalid}, 16'd0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 500; c++) begin
            logic [15:0] a0, a1;
            a0 = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 16'h1FFF : 16'h2000) : 16'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 16'h1FFF : 16'h2000) : 16'($urandom);
            seqCycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) != 0),
                     ($urandom_range(0, 1) == 1) ? 2'($urandom) : 2'b00, a0,
                     ($urandom_range(0, 7) != 0),
                     ($urandom_range(0, 1) == 1) ? 2'($urandom) : 2'b00, a1,
                     ($urandom_range(0, 7) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
